// File: rtl/alu_issue_if.sv
// alu_issue_if: ID->EX issue bus, upstream valid/ready with register operands in, decoded ALU entry out.
// master is the issue stage; slave is the surrounding pipeline.
interface alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_control;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;
    modport master (
        input  in_valid, instr, pc, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_control, rd, reg_write, illegal
    );
    modport slave (
        output in_valid, instr, pc, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_control, rd, reg_write, illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: RV32I OP/OP-IMM/LUI/AUIPC decode into an ID->EX issue register.
// With SKID_EN a second entry absorbs one extra accept so in_ready depends only on state.
module alu_issue_stage #(
    parameter bit SKID_EN = 1'b1
) (
    input logic        clk,
    input logic        rst,
    input logic        flush,
    alu_issue_if.master bus
);
    localparam logic [1:0] EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2;
    localparam logic [6:0] OPC_OP = 7'b0110011, OPC_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111;
    localparam logic [6:0] F7_ALT = 7'b0100000;
    localparam logic [3:0] C_ADD = 4'b0000, C_SUB = 4'b0001, C_AND = 4'b0010, C_OR = 4'b0011;
    localparam logic [3:0] C_XOR = 4'b0100, C_SLL = 4'b0101, C_SRL = 4'b0110, C_SRA = 4'b0111;
    localparam logic [3:0] C_SLT = 4'b1000, C_SLTU = 4'b1001, C_LUI = 4'b1010;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctl;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } entry_t;
    function automatic logic [3:0] f3_ctl(input logic [2:0] f3);
        return f3 == 3'd0 ? C_ADD : f3 == 3'd1 ? C_SLL : f3 == 3'd2 ? C_SLT :
               f3 == 3'd3 ? C_SLTU : f3 == 3'd4 ? C_XOR : f3 == 3'd5 ? C_SRL :
               f3 == 3'd6 ? C_OR : C_AND;
    endfunction
    logic [1:0]  state;
    entry_t      head, skid, dec;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic [31:0] upper, a, b;
    logic [3:0]  ctl;
    logic        ok, acc, pop;
    logic        unused_rs1_field;
    assign opc   = bus.instr[6:0];
    assign f3    = bus.instr[14:12];
    assign f7    = bus.instr[31:25];
    assign upper = {bus.instr[31:12], 12'b0};
    assign unused_rs1_field = ^bus.instr[19:15];
    always_comb begin
        ctl = f3_ctl(f3);
        a   = bus.rs1_data;
        b   = bus.rs2_data;
        ok  = 1'b0;
        case (opc)
            OPC_OP: begin
                ok  = f7 == 7'd0 || (f7 == F7_ALT && (f3 == 3'b000 || f3 == 3'b101));
                ctl = f7[5] ? (f3[2] ? C_SRA : C_SUB) : f3_ctl(f3);
            end
            OPC_IMM: begin
                // f3 x01 are the shifts: 5-bit shamt, funct7 selects logical/arithmetic
                b   = f3[1:0] == 2'b01 ? {27'b0, bus.instr[24:20]} : {{20{bus.instr[31]}}, bus.instr[31:20]};
                ok  = f3[1:0] != 2'b01 || f7 == 7'd0 || (f3 == 3'b101 && f7 == F7_ALT);
                ctl = (f3 == 3'b101 && f7[5]) ? C_SRA : f3_ctl(f3);
            end
            OPC_LUI: begin
                ok  = 1'b1;
                ctl = C_LUI;
                a   = '0;
                b   = upper;
            end
            OPC_AUIPC: begin
                ok  = 1'b1;
                ctl = C_ADD;
                a   = bus.pc;
                b   = upper;
            end
            default: ok = 1'b0;
        endcase
        dec.a   = ok ? a : '0;
        dec.b   = ok ? b : '0;
        dec.ctl = ok ? ctl : C_ADD;
        dec.rd  = bus.instr[11:7];
        dec.rw  = ok && bus.instr[11:7] != 5'd0;
        dec.ill = !ok;
    end
    assign bus.in_ready = SKID_EN ? state != TWO : state == EMPTY || bus.out_ready;
    assign bus.out_valid = state != EMPTY;
    assign acc = bus.in_valid && bus.in_ready;
    assign pop = bus.out_valid && bus.out_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
            head  <= '0;
            skid  <= '0;
        end else if (flush) begin
            state <= EMPTY;
        end else if (acc && (state == EMPTY || pop)) begin
            head  <= dec;
            state <= ONE;
        end else if (acc) begin
            skid  <= dec;
            state <= TWO;
        end else if (pop) begin
            if (state == TWO) head <= skid;
            state <= state == TWO ? ONE : EMPTY;
        end
    end
    assign bus.alu_a       = head.a;
    assign bus.alu_b       = head.b;
    assign bus.alu_control = head.ctl;
    assign bus.rd          = head.rd;
    assign bus.reg_write   = head.rw;
    assign bus.illegal     = head.ill;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed issue-stage bench; hand-decoded entries queue on accept and check on output.
module tb_alu_issue_stage;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctl;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } ent_t;
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        ent_t        e;
    } vec_t;
    logic clk, rst, flush;
    alu_issue_if bus ();
    alu_issue_stage dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));
    vec_t v [13];
    ent_t sb [$];
    ent_t cur;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   acc;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish before 100000");
        $fatal(1, "watchdog");
    end
    function automatic ent_t observed();
        return {bus.alu_a, bus.alu_b, bus.alu_control, bus.rd, bus.reg_write, bus.illegal};
    endfunction
    task automatic chk_e(input string tag, input ent_t obs, input ent_t exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic chk_b(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask
    task automatic setv(input int i, input logic [31:0] instr, input logic [31:0] pc,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] a,
                        input logic [31:0] b, input logic [3:0] ctl, input logic [4:0] rd,
                        input logic rw, input logic ill);
        v[i].instr = instr;
        v[i].pc    = pc;
        v[i].rs1   = rs1;
        v[i].rs2   = rs2;
        v[i].e     = {a, b, ctl, rd, rw, ill};
    endtask
    task automatic drive(input int i);
        bus.in_valid = 1'b1;
        bus.instr    = v[i].instr;
        bus.pc       = v[i].pc;
        bus.rs1_data = v[i].rs1;
        bus.rs2_data = v[i].rs2;
        cur          = v[i].e;
    endtask
    task automatic idle();
        bus.in_valid = 1'b0;
        bus.instr    = 32'h0000_0013;
    endtask
    // One cycle: settle, score this cycle's transfers, then advance to the next falling edge.
    task automatic tick(output bit accepted);
        #1;
        accepted = bus.in_valid && bus.in_ready && !flush && !rst;
        if (rst || flush) begin
            sb.delete();
        end else if (bus.out_valid && bus.out_ready) begin
            n_tests++;
            assert (sb.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_out: observed %h expected no output", observed());
            end
            if (sb.size() != 0) chk_e("scoreboard", observed(), sb.pop_front());
        end
        if (accepted) sb.push_back(cur);
        @(negedge clk);
    endtask
    initial begin
        setv(0,  32'h40B5_0533, 32'h100,  32'd5,        32'd3,       32'd5,        32'd3,        4'b0001, 5'd10, 1'b1, 1'b0);
        setv(1,  32'hFFF0_0293, 32'h104,  32'd0,        32'h77,      32'd0,        32'hFFFF_FFFF, 4'b0000, 5'd5,  1'b1, 1'b0);
        setv(2,  32'h1234_50B7, 32'h108,  32'hDEAD,     32'd0,       32'd0,        32'h1234_5000, 4'b1010, 5'd1,  1'b1, 1'b0);
        setv(3,  32'h4072_5193, 32'h10C,  32'h8000_0000, 32'd1,      32'h8000_0000, 32'd7,        4'b0111, 5'd3,  1'b1, 1'b0);
        setv(4,  32'hFE00_0033, 32'h110,  32'd9,        32'd9,       32'd0,        32'd0,        4'b0000, 5'd0,  1'b0, 1'b1);
        setv(5,  32'hABCD_E297, 32'h1000, 32'd4,        32'd6,       32'h1000,     32'hABCD_E000, 4'b0000, 5'd5,  1'b1, 1'b0);
        setv(6,  32'h0020_F033, 32'h118,  32'hF0F0,     32'h0FF0,    32'hF0F0,     32'h0FF0,     4'b0010, 5'd0,  1'b0, 1'b0);
        setv(7,  32'h0000_0F8F, 32'h11C,  32'd1,        32'd2,       32'd0,        32'd0,        4'b0000, 5'd31, 1'b0, 1'b1);
        setv(8,  32'h8003_A313, 32'h120,  32'd123,      32'd0,       32'd123,      32'hFFFF_F800, 4'b1000, 5'd6,  1'b1, 1'b0);
        setv(9,  32'h41F4_9413, 32'h124,  32'd8,        32'd8,       32'd0,        32'd0,        4'b0000, 5'd8,  1'b0, 1'b1);
        setv(10, 32'h0031_50B3, 32'h128,  32'h44,       32'h55,      32'h44,       32'h55,       4'b0110, 5'd1,  1'b1, 1'b0);
        setv(11, 32'h40B5_1533, 32'h12C,  32'd7,        32'd7,       32'd0,        32'd0,        4'b0000, 5'd10, 1'b0, 1'b1);
        setv(12, 32'h0051_9113, 32'h130,  32'd1,        32'd2,       32'd1,        32'd5,        4'b0101, 5'd2,  1'b1, 1'b0);
        rst = 1'b1;
        flush = 1'b0;
        bus.out_ready = 1'b0;
        bus.pc = '0;
        bus.rs1_data = '0;
        bus.rs2_data = '0;
        idle();
        repeat (3) @(negedge clk);
        #1;
        chk_e("reset_entry", observed(), '0);
        chk_b("reset_out_valid", bus.out_valid, 1'b0);
        rst = 1'b0;
        #1;
        chk_b("reset_in_ready", bus.in_ready, 1'b1);
        drive(0);
        tick(acc);
        chk_b("single_accept", acc, 1'b1);
        idle();
        #1;
        chk_b("single_out_valid", bus.out_valid, 1'b1);
        chk_e("single_latency1", observed(), v[0].e);
        tick(acc);
        tick(acc);
        chk_e("hold_stable", observed(), v[0].e);
        bus.out_ready = 1'b1;
        tick(acc);
        chk_b("single_drained", bus.out_valid, 1'b0);
        bus.out_ready = 1'b0;
        drive(1);
        tick(acc);
        chk_b("bp_accept0", acc, 1'b1);
        drive(2);
        tick(acc);
        chk_b("bp_accept1", acc, 1'b1);
        drive(3);
        #1;
        chk_b("bp_full_in_ready", bus.in_ready, 1'b0);
        tick(acc);
        chk_b("bp_held", acc, 1'b0);
        chk_e("bp_head_stable", observed(), v[1].e);
        bus.out_ready = 1'b1;
        tick(acc);
        chk_b("bp_no_accept_from_two", acc, 1'b0);
        chk_b("bp_no_gap0", bus.out_valid, 1'b1);
        tick(acc);
        chk_b("bp_accept2", acc, 1'b1);
        idle();
        chk_b("bp_no_gap1", bus.out_valid, 1'b1);
        tick(acc);
        chk_b("bp_empty", bus.out_valid, 1'b0);
        for (int i = 4; i < 13; i++) begin
            drive(i);
            #1;
            chk_b("stream_in_ready", bus.in_ready, 1'b1);
            if (i > 4) chk_b("stream_out_valid", bus.out_valid, 1'b1);
            tick(acc);
            chk_b("stream_accept", acc, 1'b1);
        end
        idle();
        chk_b("stream_last_valid", bus.out_valid, 1'b1);
        tick(acc);
        chk_b("stream_drained", sb.size() == 0, 1'b1);
        bus.out_ready = 1'b0;
        drive(0);
        tick(acc);
        drive(1);
        tick(acc);
        #1;
        chk_b("flush_state_two", bus.in_ready, 1'b0);
        drive(2);
        flush = 1'b1;
        bus.out_ready = 1'b1;
        tick(acc);
        flush = 1'b0;
        idle();
        #1;
        chk_b("flush_out_valid", bus.out_valid, 1'b0);
        chk_b("flush_in_ready", bus.in_ready, 1'b1);
        repeat (3) begin
            tick(acc);
            chk_b("flush_stays_empty", bus.out_valid, 1'b0);
        end
        drive(5);
        tick(acc);
        idle();
        chk_e("post_flush_entry", observed(), v[5].e);
        tick(acc);
        bus.out_ready = 1'b0;
        drive(3);
        tick(acc);
        drive(4);
        tick(acc);
        drive(6);
        rst = 1'b1;
        tick(acc);
        rst = 1'b0;
        idle();
        #1;
        chk_e("rst_mid_entry", observed(), '0);
        chk_b("rst_mid_out_valid", bus.out_valid, 1'b0);
        chk_b("rst_mid_in_ready", bus.in_ready, 1'b1);
        bus.out_ready = 1'b1;
        repeat (2) begin
            tick(acc);
            chk_b("rst_stays_empty", bus.out_valid, 1'b0);
        end
        drive(8);
        tick(acc);
        idle();
        tick(acc);
        chk_b("final_drained", sb.size() == 0, 1'b1);
        chk_b("final_empty", bus.out_valid, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
